// File: rtl/decode_pattern_gen_pkg.sv
// Shared types and constants for the registered decode / alternating-pattern
// output block.
package decode_pattern_pkg;

   typedef enum logic [1:0] {
      MODE_OFF  = 2'd0,
      MODE_DEC  = 2'd1,
      MODE_PAT  = 2'd2,
      MODE_HOLD = 2'd3
   } mode_e;

   localparam logic [7:0] PAT_A_DEF = 8'h33;
   localparam logic [7:0] PAT_B_DEF = 8'hCC;

   // A single-cycle phase still needs one counter bit to keep the ports regular.
   function automatic int cnt_width(input int period);
      if (period <= 1) return 1;
      return $clog2(period);
   endfunction

endpackage

// File: rtl/decode_pattern_gen_if.sv
// Request/select inputs and registered outputs of decode_pattern_gen.
// Inputs are sampled on every rising CLK edge; there is no valid/ready
// handshake. Outputs are pure flop outputs, so they carry no combinational
// path from any input.
interface decode_pattern_gen_if
   import decode_pattern_pkg::*;
#(
   parameter int SEL_W = 3
);
   localparam int OUT_W = 2 ** SEL_W;

   logic             EN;
   logic             A;
   logic             B;
   logic [SEL_W-1:0] IN;
   logic [OUT_W-1:0] OUT;
   logic             PHASE;
   logic             TICK;
   mode_e            MODE;   // mode applied at the most recent edge

   modport master (
      output EN, A, B, IN,
      input  OUT, PHASE, TICK, MODE
   );

   modport slave (
      input  EN, A, B, IN,
      output OUT, PHASE, TICK, MODE
   );

endinterface

// File: rtl/decode_pattern_gen_pattern_timer.sv
// Dwell counter and phase flop for the alternating pattern; flips PHASE and
// pulses TICK after PERIOD run cycles, clears on clr, freezes otherwise.
module pattern_timer
   import decode_pattern_pkg::*;
#(
   parameter int PERIOD = 1
) (
   input  logic CLK,
   input  logic RST_N,
   input  logic clr,
   input  logic run,
   output logic PHASE,
   output logic TICK
);

   if (PERIOD < 1) begin : g_bad_period
      $error("pattern_timer: PERIOD must be >= 1");
   end

   localparam int                CNT_W    = cnt_width(PERIOD);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(PERIOD - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             phase_q, phase_d;
   logic             tick_q, tick_d;

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         cnt_q   <= '0;
         phase_q <= 1'b0;
         tick_q  <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         phase_q <= phase_d;
         tick_q  <= tick_d;
      end
   end

   // clr wins over run; with neither, count and phase freeze mid-dwell.
   always_comb begin
      cnt_d   = cnt_q;
      phase_d = phase_q;
      tick_d  = 1'b0;
      if (clr) begin
         cnt_d   = '0;
         phase_d = 1'b0;
      end else if (run) begin
         if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
            tick_d  = 1'b1;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   assign PHASE = phase_q;
   assign TICK  = tick_q;

endmodule

// File: rtl/decode_pattern_gen.sv
// Registered one-hot decoder / two-phase pattern generator for LED and
// segment-style output drivers.
module decode_pattern_gen
   import decode_pattern_pkg::*;
#(
   parameter int SEL_W  = 3,
   parameter int PERIOD = 1,
   parameter     PAT_A  = PAT_A_DEF,
   parameter     PAT_B  = PAT_B_DEF
) (
   input  logic                 CLK,
   input  logic                 RST_N,
   decode_pattern_gen_if.slave  bus
);

   localparam int               OUT_W   = 2 ** SEL_W;
   localparam logic [OUT_W-1:0] PAT_A_W = OUT_W'(PAT_A);
   localparam logic [OUT_W-1:0] PAT_B_W = OUT_W'(PAT_B);

   mode_e            mode_d, mode_q;
   logic [OUT_W-1:0] out_d, out_q;
   logic             phase;
   logic             tick;
   logic             tmr_clr;
   logic             tmr_run;

   // Priority: EN low, then decode request, then pattern request, else hold.
   always_comb begin
      mode_d = MODE_HOLD;
      if (!bus.EN)     mode_d = MODE_OFF;
      else if (bus.A)  mode_d = MODE_DEC;
      else if (bus.B)  mode_d = MODE_PAT;
   end

   assign tmr_clr = (mode_d == MODE_OFF) || (mode_d == MODE_DEC);
   assign tmr_run = (mode_d == MODE_PAT);

   pattern_timer #(
      .PERIOD (PERIOD)
   ) u_timer (
      .CLK   (CLK),
      .RST_N (RST_N),
      .clr   (tmr_clr),
      .run   (tmr_run),
      .PHASE (phase),
      .TICK  (tick)
   );

   // Pattern output uses the phase from before this edge, so the flip and
   // the TICK pulse lead the first output of the new phase by one cycle.
   always_comb begin
      out_d = out_q;
      case (mode_d)
         MODE_OFF:  out_d = '0;
         MODE_DEC:  out_d = OUT_W'(1) << bus.IN;
         MODE_PAT:  out_d = phase ? PAT_B_W : PAT_A_W;
         default:   out_d = out_q;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         out_q  <= '0;
         mode_q <= MODE_OFF;
      end else begin
         out_q  <= out_d;
         mode_q <= mode_d;
      end
   end

   assign bus.OUT   = out_q;
   assign bus.PHASE = phase;
   assign bus.TICK  = tick;
   assign bus.MODE  = mode_q;

endmodule

// File: tb/tb_decode_pattern_gen.sv
// Directed bench: three instances (PERIOD 1, 3, 4) share one stimulus stream.
module tb_decode_pattern_gen;
   import decode_pattern_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       en, a, b;
   logic [2:0] in_sel;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   decode_pattern_gen_if #(.SEL_W(3)) if1 ();
   decode_pattern_gen_if #(.SEL_W(3)) if3 ();
   decode_pattern_gen_if #(.SEL_W(3)) if4 ();

   assign if1.EN = en;  assign if1.A = a;  assign if1.B = b;  assign if1.IN = in_sel;
   assign if3.EN = en;  assign if3.A = a;  assign if3.B = b;  assign if3.IN = in_sel;
   assign if4.EN = en;  assign if4.A = a;  assign if4.B = b;  assign if4.IN = in_sel;

   decode_pattern_gen #(.SEL_W(3), .PERIOD(1)) dut1 (.CLK(clk), .RST_N(rst_n), .bus(if1));
   decode_pattern_gen #(.SEL_W(3), .PERIOD(3)) dut3 (.CLK(clk), .RST_N(rst_n), .bus(if3));
   decode_pattern_gen #(.SEL_W(3), .PERIOD(4)) dut4 (.CLK(clk), .RST_N(rst_n), .bus(if4));

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   logic [7:0] dec_tab   [8]  = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
   logic [7:0] p3_out    [12] = '{8'h33, 8'h33, 8'h33, 8'hCC, 8'hCC, 8'hCC,
                                  8'h33, 8'h33, 8'h33, 8'hCC, 8'hCC, 8'hCC};
   logic       p3_tick   [12] = '{0, 0, 1, 0, 0, 1, 0, 0, 1, 0, 0, 1};
   logic       p3_phase  [12] = '{0, 0, 1, 1, 1, 0, 0, 0, 1, 1, 1, 0};
   logic [7:0] p1_out    [12] = '{8'h33, 8'hCC, 8'h33, 8'hCC, 8'h33, 8'hCC,
                                  8'h33, 8'hCC, 8'h33, 8'hCC, 8'h33, 8'hCC};
   logic [7:0] p4_out    [12] = '{8'h33, 8'h33, 8'h33, 8'h33, 8'hCC, 8'hCC,
                                  8'hCC, 8'hCC, 8'h33, 8'h33, 8'h33, 8'h33};
   logic       p4_tick   [12] = '{0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 1};
   logic [7:0] rst4_out  [5]  = '{8'h33, 8'h33, 8'h33, 8'h33, 8'hCC};
   logic       rst4_tick [5]  = '{0, 0, 0, 1, 0};

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset held with every request asserted
      rst_n = 1'b0; en = 1'b1; a = 1'b1; b = 1'b1; in_sel = 3'd3;
      step(); step();
      chk("rst_out3",   32'(if3.OUT),   32'h0);
      chk("rst_phase3", 32'(if3.PHASE), 32'h0);
      chk("rst_tick3",  32'(if3.TICK),  32'h0);
      chk("rst_out4",   32'(if4.OUT),   32'h0);
      chk("rst_mode3",  32'(if3.MODE),  32'(MODE_OFF));

      // Decode sweep
      rst_n = 1'b1; a = 1'b1; b = 1'b0;
      for (int i = 0; i < 8; i++) begin
         in_sel = 3'(i);
         step();
         chk("dec_out",   32'(if3.OUT),   32'(dec_tab[i]));
         chk("dec_phase", 32'(if3.PHASE), 32'h0);
         chk("dec_tick",  32'(if3.TICK),  32'h0);
      end
      chk("dec_mode", 32'(if3.MODE), 32'(MODE_DEC));

      // OFF clears
      en = 1'b0;
      step();
      chk("off_out", 32'(if3.OUT), 32'h0);

      // Pattern run from cleared state
      en = 1'b1; a = 1'b0; b = 1'b1;
      for (int k = 0; k < 12; k++) begin
         step();
         chk("pat3_out",   32'(if3.OUT),   32'(p3_out[k]));
         chk("pat3_tick",  32'(if3.TICK),  32'(p3_tick[k]));
         chk("pat3_phase", 32'(if3.PHASE), 32'(p3_phase[k]));
         chk("pat1_out",   32'(if1.OUT),   32'(p1_out[k]));
         chk("pat1_tick",  32'(if1.TICK),  32'h1);
         chk("pat4_out",   32'(if4.OUT),   32'(p4_out[k]));
         chk("pat4_tick",  32'(if4.TICK),  32'(p4_tick[k]));
      end
      chk("pat_mode", 32'(if3.MODE), 32'(MODE_PAT));

      // Decode pre-empts pattern mid-phase-1 and clears it
      en = 1'b0; step();
      en = 1'b1; b = 1'b1;
      repeat (4) step();
      chk("pri_pre_out",   32'(if3.OUT),   32'hCC);
      chk("pri_pre_phase", 32'(if3.PHASE), 32'h1);
      a = 1'b1; in_sel = 3'd5;
      step();
      chk("pri_dec_out3",  32'(if3.OUT),   32'h20);
      chk("pri_dec_phase", 32'(if3.PHASE), 32'h0);
      chk("pri_dec_tick",  32'(if3.TICK),  32'h0);
      chk("pri_dec_out1",  32'(if1.OUT),   32'h20);
      a = 1'b0;
      for (int k = 0; k < 3; k++) begin
         step();
         chk("pri_restart_out",   32'(if3.OUT),   32'h33);
         chk("pri_restart_tick",  32'(if3.TICK),  32'(p3_tick[k]));
         chk("pri_restart_phase", 32'(if3.PHASE), 32'(p3_phase[k]));
      end

      // HOLD freezes mid-phase, then resumes without restart
      en = 1'b0; step();
      en = 1'b1; b = 1'b1;
      step(); step();
      chk("hold_pre_out", 32'(if3.OUT), 32'h33);
      b = 1'b0;
      for (int k = 0; k < 5; k++) begin
         step();
         chk("hold_out3",   32'(if3.OUT),   32'h33);
         chk("hold_phase3", 32'(if3.PHASE), 32'h0);
         chk("hold_tick3",  32'(if3.TICK),  32'h0);
         if (k == 0) begin
            chk("hold_out1",  32'(if1.OUT),  32'hCC);
            chk("hold_tick1", 32'(if1.TICK), 32'h0);
            chk("hold_mode",  32'(if3.MODE), 32'(MODE_HOLD));
         end
      end
      b = 1'b1;
      step();
      chk("resume_out",   32'(if3.OUT),   32'h33);
      chk("resume_phase", 32'(if3.PHASE), 32'h1);
      chk("resume_tick",  32'(if3.TICK),  32'h1);
      step();
      chk("resume_out_b", 32'(if3.OUT),   32'hCC);
      chk("resume_tick2", 32'(if3.TICK),  32'h0);

      // Synchronous reset mid-dwell on the PERIOD=4 instance
      en = 1'b0; step();
      en = 1'b1; b = 1'b1;
      step(); step();
      rst_n = 1'b0;
      step();
      chk("mrst_out4",   32'(if4.OUT),   32'h0);
      chk("mrst_phase4", 32'(if4.PHASE), 32'h0);
      chk("mrst_tick4",  32'(if4.TICK),  32'h0);
      rst_n = 1'b1;
      for (int k = 0; k < 5; k++) begin
         step();
         chk("mrst_seq_out",  32'(if4.OUT),  32'(rst4_out[k]));
         chk("mrst_seq_tick", 32'(if4.TICK), 32'(rst4_tick[k]));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
